shape_cmd_issuer: RTL and testbench

- Front end of the 2D GPU core, on the initiator side of the newshape/shapedone handshake into the core control unit.
- Accepts host command words over a valid/ready stream and parses them into shape descriptors (shape id plus up to three vertices).
- Buffers descriptors in a small queue.
- Issues one descriptor at a time to the core control unit, and holds it stable until the core reports shapedone.

---
 rtl/shape_cmd_issuer.sv | 187 ++++++++++++++++++
 tb/tb_shape_cmd_issuer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : shape_cmd_issuer
// Purpose  : Parses host command words into shape descriptors, queues them and
//            issues one at a time over the newshape/shapedone handshake.
//            Define SHAPECNT_EN to add the shapecount completion counter.
// Revision : 1.0
// ============================================================================
module shape_cmd_issuer #(
  parameter int COORDW = 10,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmdvalid,
  input  logic [31:0]       cmddata,
  output logic              cmdready,
  input  logic              shapedone,
  output logic              newshape,
  output logic [3:0]        shapeid,
  output logic [COORDW-1:0] x0,
  output logic [COORDW-1:0] y0,
  output logic [COORDW-1:0] x1,
  output logic [COORDW-1:0] y1,
  output logic [COORDW-1:0] x2,
  output logic [COORDW-1:0] y2,
  output logic              empty,
  output logic              busy,
  output logic              cmderr
`ifdef SHAPECNT_EN
  ,
  output logic [15:0]       shapecount
`endif
);

  localparam int c_AW = $clog2(QDEPTH);
  localparam int c_DW = 4 + 6 * COORDW;
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(QDEPTH);

  typedef enum logic [1:0] {PHDR = 2'd0, PARG = 2'd1, PHOLD = 2'd2} pstate_t;
  typedef enum logic [1:0] {IIDLE = 2'd0, IISSUE = 2'd1, IWAIT = 2'd2} istate_t;

  pstate_t r_pstate, w_pstate_nx;
  istate_t r_istate, w_istate_nx;

  logic [3:0]             r_pid;
  logic [1:0]             r_nops;
  logic [1:0]             r_idx;
  logic [2:0][COORDW-1:0] r_vx, r_vy, w_dx, w_dy;
  logic [c_AW:0]          r_wptr, r_rptr, w_wptr_nx, w_rptr_nx, w_count;
  logic [c_DW-1:0]        r_mem [QDEPTH];
  logic                   r_empty, r_cmderr;
  logic [3:0]             r_oid;
  logic [2:0][COORDW-1:0] r_ox, r_oy;

  logic              w_xfer, w_hdr_ok, w_last, w_room, w_push, w_pop;
  logic [COORDW-1:0] w_opx, w_opy;
  logic              w_unused_bits;

  assign cmdready  = (r_pstate != PHOLD);
  assign w_xfer    = cmdvalid & cmdready;
  assign w_opx     = cmddata[COORDW-1:0];
  assign w_opy     = cmddata[16+COORDW-1:16];
  assign w_hdr_ok  = (cmddata[3:0] <= 4'd2);
  assign w_last    = (r_pstate == PARG) && w_xfer && (r_idx == r_nops - 2'd1);
  assign w_pop     = (r_istate == IIDLE) && !r_empty;
  assign w_count   = r_wptr - r_rptr;
  // A pop on the same edge frees a slot, so a full queue can still accept.
  assign w_room    = (w_count != c_DEPTH) || w_pop;
  assign w_push    = (w_last || (r_pstate == PHOLD)) && w_room;
  assign w_wptr_nx = r_wptr + {{c_AW{1'b0}}, w_push};
  assign w_rptr_nx = r_rptr + {{c_AW{1'b0}}, w_pop};
  assign w_unused_bits = ^cmddata;

  always_comb begin
    w_dx = r_vx;
    w_dy = r_vy;
    if ((r_pstate == PARG) && w_xfer) begin
      case (r_idx)
        2'd0:    begin w_dx[0] = w_opx; w_dy[0] = w_opy; end
        2'd1:    begin w_dx[1] = w_opx; w_dy[1] = w_opy; end
        default: begin w_dx[2] = w_opx; w_dy[2] = w_opy; end
      endcase
    end
  end

  always_comb begin
    w_pstate_nx = r_pstate;
    case (r_pstate)
      PHDR:    if (w_xfer && w_hdr_ok) w_pstate_nx = PARG;
      PARG:    if (w_last) w_pstate_nx = w_room ? PHDR : PHOLD;
      PHOLD:   if (w_room) w_pstate_nx = PHDR;
      default: w_pstate_nx = PHDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pstate <= PHDR;
      r_pid    <= 4'd0;
      r_nops   <= 2'd0;
      r_idx    <= 2'd0;
      r_vx     <= '0;
      r_vy     <= '0;
    end else begin
      r_pstate <= w_pstate_nx;
      if ((r_pstate == PHDR) && w_xfer && w_hdr_ok) begin
        r_pid  <= cmddata[3:0];
        r_nops <= (cmddata[3:0] == 4'd1) ? 2'd3 : 2'd2;
        r_idx  <= 2'd0;
        r_vx   <= '0;
        r_vy   <= '0;
      end else if ((r_pstate == PARG) && w_xfer) begin
        r_vx  <= w_dx;
        r_vy  <= w_dy;
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[c_AW-1:0]] <= {r_pid, w_dx, w_dy};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nx;
      r_rptr  <= w_rptr_nx;
      r_empty <= (w_wptr_nx == w_rptr_nx);
    end
  end

  always_comb begin
    w_istate_nx = r_istate;
    case (r_istate)
      IIDLE:   if (!r_empty) w_istate_nx = IISSUE;
      IISSUE:  w_istate_nx = IWAIT;
      IWAIT:   if (shapedone) w_istate_nx = IIDLE;
      default: w_istate_nx = IIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_istate <= IIDLE;
      r_oid    <= 4'd0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_cmderr <= 1'b0;
    end else begin
      r_istate <= w_istate_nx;
      if (w_pop) {r_oid, r_ox, r_oy} <= r_mem[r_rptr[c_AW-1:0]];
      if (((r_pstate == PHDR) && w_xfer && !w_hdr_ok) ||
          (shapedone && (r_istate != IWAIT)))
        r_cmderr <= 1'b1;
    end
  end

`ifdef SHAPECNT_EN
  logic [15:0] r_shapecnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_shapecnt <= 16'd0;
    else if ((r_istate == IWAIT) && shapedone)
      r_shapecnt <= r_shapecnt + 16'd1;
  end
  assign shapecount = r_shapecnt;
`endif

  assign newshape = (r_istate == IISSUE);
  assign busy     = (r_istate == IISSUE) || (r_istate == IWAIT);
  assign empty    = r_empty;
  assign cmderr   = r_cmderr;
  assign shapeid  = r_oid;
  assign x0 = r_ox[0];
  assign y0 = r_oy[0];
  assign x1 = r_ox[1];
  assign y1 = r_oy[1];
  assign x2 = r_ox[2];
  assign y2 = r_oy[2];

endmodule
`default_nettype wire

// File: tb/tb_shape_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shape_cmd_issuer
// Purpose  : Self-checking bench for shape_cmd_issuer (vector table plus
//            directed multi-cycle sequences).
// Revision : 1.0
// ============================================================================
module tb_shape_cmd_issuer;

  typedef struct packed {
    logic [3:0] id;
    logic [9:0] x0, y0, x1, y1, x2, y2;
  } desc_t;

  typedef struct {
    logic  v;
    logic [31:0] d;
    logic  sd;
    logic  ns, bsy, emp, rdy, err;
    logic  chk;
    desc_t dsc;
  } vec_t;

  logic clk = 1'b0;
  logic reset, cmdvalid, shapedone, cmdready, newshape, empty, busy, cmderr;
  logic [31:0] cmddata;
  logic [3:0]  shapeid;
  logic [9:0]  x0, y0, x1, y1, x2, y2;
`ifdef SHAPECNT_EN
  logic [15:0] shapecount;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  desc_t log_q[$];
  int    ns_cyc[$];
  vec_t  tbl[17];

  shape_cmd_issuer #(.COORDW(10), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmdvalid(cmdvalid), .cmddata(cmddata),
    .cmdready(cmdready), .shapedone(shapedone), .newshape(newshape),
    .shapeid(shapeid), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .empty(empty), .busy(busy), .cmderr(cmderr)
`ifdef SHAPECNT_EN
    , .shapecount(shapecount)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic desc_t mkd(input logic [3:0] id, input logic [9:0] a, b, c, d, e, f);
    return '{id: id, x0: a, y0: b, x1: c, y1: d, x2: e, y2: f};
  endfunction

  function automatic logic [31:0] opw(input logic [9:0] x, input logic [9:0] y);
    return {6'd0, y, 6'd0, x};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic sd,
                              input logic ns, bsy, emp, rdy, err,
                              input logic chk, input desc_t dsc);
    return '{v: v, d: d, sd: sd, ns: ns, bsy: bsy, emp: emp, rdy: rdy, err: err,
             chk: chk, dsc: dsc};
  endfunction

  function automatic desc_t cur();
    return mkd(shapeid, x0, y0, x1, y1, x2, y2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Issued descriptors are logged; while a shape is outstanding the buses must hold.
  always @(negedge clk) begin
    if (newshape) begin
      log_q.push_back(cur());
      ns_cyc.push_back(cyc);
    end else if (busy && log_q.size() > 0) begin
      check("hold_stable", 64'(cur()), 64'(log_q[$]));
    end
  end

  task automatic do_reset();
    reset = 1'b1; cmdvalid = 1'b0; cmddata = '0; shapedone = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete();
    ns_cyc.delete();
  endtask

  task automatic send(input logic [31:0] w);
    logic rdy;
    cmdvalid = 1'b1;
    cmddata  = w;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      rdy = cmdready;
      @(posedge clk);
      #1;
      if (rdy) begin
        cmdvalid = 1'b0;
        return;
      end
    end
    cmdvalid = 1'b0;
    timeout("send");
  endtask

  task automatic send_line(input logic [9:0] a, b, c, d);
    send(32'h0);
    send(opw(a, b));
    send(opw(c, d));
  endtask

  task automatic wait_size(input int n);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (log_q.size() >= n) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    timeout("wait_newshape");
  endtask

  task automatic pulse_done();
    shapedone = 1'b1;
    @(posedge clk);
    #1 shapedone = 1'b0;
  endtask

  initial begin
    int c;
    int n;
    logic r1, r2;
    desc_t d_l1, d_l2, d_tri, d_arc;

    d_l1  = mkd(4'd0, 10'd5, 10'd7, 10'd300, 10'd12, 10'd0, 10'd0);
    d_l2  = mkd(4'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd0);
    d_tri = mkd(4'd1, 10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60);
    d_arc = mkd(4'd2, 10'd100, 10'd110, 10'd7, 10'd0, 10'd0, 10'd0);

    //            v  data             sd  ns bsy emp rdy err chk
    tbl[0]  = mk(1, 32'h0,            0,  0, 0,  1,  1,  0,  0, '0);
    tbl[1]  = mk(1, opw(5, 7),        0,  0, 0,  1,  1,  0,  0, '0);
    tbl[2]  = mk(1, opw(300, 12),     0,  0, 0,  1,  1,  0,  0, '0);
    tbl[3]  = mk(0, 32'h0,            0,  0, 0,  0,  1,  0,  0, '0);
    tbl[4]  = mk(0, 32'h0,            0,  1, 1,  1,  1,  0,  1, d_l1);
    tbl[5]  = mk(0, 32'h0,            0,  0, 1,  1,  1,  0,  1, d_l1);
    tbl[6]  = mk(0, 32'h0,            1,  0, 1,  1,  1,  0,  1, d_l1);
    tbl[7]  = mk(0, 32'h0,            0,  0, 0,  1,  1,  0,  0, '0);
    tbl[8]  = mk(1, 32'h5,            0,  0, 0,  1,  1,  0,  0, '0);
    tbl[9]  = mk(0, 32'h0,            1,  0, 0,  1,  1,  1,  0, '0);
    tbl[10] = mk(1, 32'h0,            0,  0, 0,  1,  1,  1,  0, '0);
    tbl[11] = mk(1, opw(1, 2),        0,  0, 0,  1,  1,  1,  0, '0);
    tbl[12] = mk(1, opw(3, 4),        0,  0, 0,  1,  1,  1,  0, '0);
    tbl[13] = mk(0, 32'h0,            0,  0, 0,  0,  1,  1,  0, '0);
    tbl[14] = mk(0, 32'h0,            0,  1, 1,  1,  1,  1,  1, d_l2);
    tbl[15] = mk(0, 32'h0,            1,  0, 1,  1,  1,  1,  1, d_l2);
    tbl[16] = mk(0, 32'h0,            0,  0, 0,  1,  1,  1,  0, '0);

    // Reset values, sampled while reset is held.
    reset = 1'b1; cmdvalid = 1'b0; cmddata = '0; shapedone = 1'b0;
    @(negedge clk);
    check("rst.newshape", 64'(newshape), 64'd0);
    check("rst.busy",     64'(busy),     64'd0);
    check("rst.empty",    64'(empty),    64'd1);
    check("rst.cmdready", 64'(cmdready), 64'd1);
    check("rst.cmderr",   64'(cmderr),   64'd0);
    check("rst.desc",     64'(cur()),    64'd0);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      cmdvalid  = tbl[i].v;
      cmddata   = tbl[i].d;
      shapedone = tbl[i].sd;
      @(negedge clk);
      check($sformatf("v%0d.newshape", i), 64'(newshape), 64'(tbl[i].ns));
      check($sformatf("v%0d.busy", i),     64'(busy),     64'(tbl[i].bsy));
      check($sformatf("v%0d.empty", i),    64'(empty),    64'(tbl[i].emp));
      check($sformatf("v%0d.cmdready", i), 64'(cmdready), 64'(tbl[i].rdy));
      check($sformatf("v%0d.cmderr", i),   64'(cmderr),   64'(tbl[i].err));
      if (tbl[i].chk) check($sformatf("v%0d.desc", i), 64'(cur()), 64'(tbl[i].dsc));
    end
    @(posedge clk);
    #1 cmdvalid = 1'b0; shapedone = 1'b0;

    // Triangle then arc back-to-back, shapedone 20 cycles after the first issue.
    do_reset();
    send(32'h1); send(opw(10, 20)); send(opw(30, 40)); send(opw(50, 60));
    send(32'h2); send(opw(100, 110)); send(opw(7, 0));
    wait_size(1);
    repeat (20) @(posedge clk);
    #1;
    c = cyc;
    pulse_done();
    wait_size(2);
    if (ns_cyc.size() >= 2) check("b2b.gap", 64'(ns_cyc[1]), 64'(c + 2));
    else timeout("b2b.second_issue");
    if (log_q.size() >= 2) begin
      check("b2b.tri", 64'(log_q[0]), 64'(d_tri));
      check("b2b.arc", 64'(log_q[1]), 64'(d_arc));
    end
    pulse_done();
    @(negedge clk);
    check("b2b.busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Back-pressure: one shape in flight plus four queued stalls the sixth line.
    do_reset();
    for (int k = 0; k < 6; k++) send_line(10'(k + 1), 10'(k + 11), 10'(k + 21), 10'(k + 31));
    @(negedge clk);
    check("bp.hold_ready", 64'(cmdready), 64'd0);
    check("bp.issued", 64'(log_q.size()), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp.still_held", 64'(cmdready), 64'd0);
    @(posedge clk);
    #1 shapedone = 1'b1;
    @(posedge clk);
    #1 shapedone = 1'b0;
    @(negedge clk);
    r1 = cmdready;
    @(posedge clk);
    @(negedge clk);
    r2 = cmdready;
    check("bp.ready_return", 64'(r1 | r2), 64'd1);
    @(posedge clk);
    #1;
    for (int k = 1; k < 6; k++) begin
      wait_size(k + 1);
      pulse_done();
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp.count", 64'(log_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < log_q.size(); k++)
      check($sformatf("bp.order%0d", k), 64'(log_q[k]),
            64'(mkd(4'd0, 10'(k + 1), 10'(k + 11), 10'(k + 21), 10'(k + 31), 10'd0, 10'd0)));
    check("bp.empty_end", 64'(empty), 64'd1);
    check("bp.busy_end", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Reset during IWAIT with two descriptors queued.
    do_reset();
    send_line(10'd40, 10'd41, 10'd42, 10'd43);
    send_line(10'd50, 10'd51, 10'd52, 10'd53);
    send_line(10'd60, 10'd61, 10'd62, 10'd63);
    wait_size(1);
    reset = 1'b1;
    @(negedge clk);
    check("mid.newshape", 64'(newshape), 64'd0);
    check("mid.busy",     64'(busy),     64'd0);
    check("mid.empty",    64'(empty),    64'd1);
    check("mid.cmdready", 64'(cmdready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    n = log_q.size();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid.no_reissue", 64'(log_q.size()), 64'(n));
    @(posedge clk);
    #1;
    send_line(10'd70, 10'd71, 10'd72, 10'd73);
    wait_size(n + 1);
    if (log_q.size() > n)
      check("mid.new_cmd", 64'(log_q[n]), 64'(mkd(4'd0, 10'd70, 10'd71, 10'd72, 10'd73, 10'd0, 10'd0)));
    pulse_done();

`ifdef SHAPECNT_EN
    for (int k = 0; k < 2; k++) begin
      send_line(10'(k), 10'd1, 10'd2, 10'd3);
      wait_size(n + 2 + k);
      pulse_done();
    end
    @(negedge clk);
    check("cnt.three", 64'(shapecount), 64'd3);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
